burst_main_mem: RTL and testbench

BURST_MAIN_MEM -- requirements
Module: burst_main_mem

---
 rtl/mm_pkg.sv | 24 ++
 rtl/mm_word_ram.sv | 33 +++
 rtl/burst_main_mem.sv | 152 +++++++++++++++
 tb/tb_burst_main_mem.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared types and default parameters for the burst main memory.
// Imported by the memory top and its word RAM.
package mm_pkg;

  localparam int unsigned MM_WIDTH       = 32;
  localparam int unsigned MM_DEPTH       = 1024;
  localparam int unsigned MM_BLOCK_WORDS = 4;
  localparam int unsigned MM_LATENCY     = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    XFER = 2'd2,
    RESP = 2'd3
  } mm_state_e;

  // Counter width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(
    input int unsigned v
  );
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/mm_word_ram.sv
// Single-port word RAM, one access per cycle.
// Asynchronous read, synchronous write, async active-low clear.
module mm_word_ram
  import mm_pkg::*;
#(
  parameter int unsigned WIDTH = MM_WIDTH,
  parameter int unsigned DEPTH = MM_DEPTH,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Storage: cleared on reset, one word written per cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/burst_main_mem.sv
// Burst main memory: block reads, block write-backs and
// single-word write-throughs behind a one-deep request port.
module burst_main_mem
  import mm_pkg::*;
#(
  parameter int unsigned WIDTH       = MM_WIDTH,
  parameter int unsigned DEPTH       = MM_DEPTH,
  parameter int unsigned BLOCK_WORDS = MM_BLOCK_WORDS,
  parameter int unsigned LATENCY     = MM_LATENCY,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned BW = WIDTH * BLOCK_WORDS
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic          req_block,
  input  logic [AW-1:0] req_addr,
  input  logic [BW-1:0] req_wdata,
  output logic          resp_valid,
  output logic [BW-1:0] resp_rdata,
  output logic          busy
);

  localparam int unsigned OW = $clog2(BLOCK_WORDS);
  localparam int unsigned LW = clog2_min1(LATENCY + 1);

  localparam logic [OW-1:0] CNT_LAST  = OW'(BLOCK_WORDS - 1);
  localparam logic [LW-1:0] LAT_LAST  = LW'(LATENCY - 1);
  localparam logic [AW-1:0] BASE_MASK = ~AW'(BLOCK_WORDS - 1);

  mm_state_e     state_q, state_d;
  logic [OW-1:0] cnt_q, cnt_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          wr_q, wr_d;
  logic          single_q, single_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [BW-1:0] wdata_q, wdata_d;
  logic [BW-1:0] rbuf_q, rbuf_d;
  logic [BW-1:0] rdata_q, rdata_d;

  logic [AW-1:0]    ram_addr;
  logic             ram_we;
  logic [WIDTH-1:0] ram_wdata;
  logic [WIDTH-1:0] ram_rdata;
  logic [BW-1:0]    blk;
  logic             xfer_last;

  // Block base has zero low bits, so base + count is the word address.
  assign ram_addr  = addr_q + AW'(cnt_q);
  assign ram_we    = (state_q == XFER) && wr_q;
  assign ram_wdata = wdata_q[int'(cnt_q) * WIDTH +: WIDTH];
  assign xfer_last = single_q || (cnt_q == CNT_LAST);

  mm_word_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk_i   (clk),
    .rst_ni  (reset),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  // Read buffer with the current word merged into its lane.
  always_comb begin
    blk = rbuf_q;
    blk[int'(cnt_q) * WIDTH +: WIDTH] = ram_rdata;
  end

  // Next-state logic: capture, wait, transfer, respond.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    lat_d    = lat_q;
    wr_d     = wr_q;
    single_d = single_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rbuf_d   = rbuf_q;
    rdata_d  = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          wr_d     = req_write;
          single_d = req_write & ~req_block;
          addr_d   = (req_write & ~req_block)
                   ? req_addr
                   : (req_addr & BASE_MASK);
          wdata_d  = req_wdata;
          cnt_d    = '0;
          lat_d    = '0;
          state_d  = (LATENCY == 0) ? XFER : WAIT;
        end
      end
      WAIT: begin
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = XFER;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      XFER: begin
        if (!wr_q) rbuf_d = blk;
        if (xfer_last) begin
          cnt_d   = '0;
          state_d = RESP;
          if (!wr_q) rdata_d = blk;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lat_q    <= '0;
      wr_q     <= 1'b0;
      single_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rbuf_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      wr_q     <= wr_d;
      single_q <= single_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rbuf_q   <= rbuf_d;
      rdata_q  <= rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign busy       = ~req_ready;
  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_burst_main_mem.sv
// Testbench for burst_main_mem: default build plus a
// LATENCY=0 / BLOCK_WORDS=8 build, scoreboard-checked.
module tb_burst_main_mem;

  localparam int W   = 32;
  localparam int D   = 1024;
  localparam int BWD = 4;
  localparam int LAT = 2;
  localparam int AW  = 10;
  localparam int DW  = W * BWD;

  localparam int D8  = 64;
  localparam int B8  = 8;
  localparam int L8  = 0;
  localparam int AW8 = 6;
  localparam int DW8 = W * B8;

  typedef struct {
    bit           rd;
    logic [255:0] data;
    int           lat;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic          a_valid, a_ready, a_write, a_block;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata, a_rdata;
  logic          a_resp, a_busy;

  logic           b_valid, b_ready, b_write, b_block;
  logic [AW8-1:0] b_addr;
  logic [DW8-1:0] b_wdata, b_rdata;
  logic           b_resp, b_busy;

  burst_main_mem dut (
    .clk(clk), .reset(rst_n),
    .req_valid(a_valid), .req_ready(a_ready),
    .req_write(a_write), .req_block(a_block),
    .req_addr(a_addr), .req_wdata(a_wdata),
    .resp_valid(a_resp), .resp_rdata(a_rdata),
    .busy(a_busy)
  );

  burst_main_mem #(
    .WIDTH(W), .DEPTH(D8), .BLOCK_WORDS(B8), .LATENCY(L8)
  ) dut8 (
    .clk(clk), .reset(rst_n),
    .req_valid(b_valid), .req_ready(b_ready),
    .req_write(b_write), .req_block(b_block),
    .req_addr(b_addr), .req_wdata(b_wdata),
    .resp_valid(b_resp), .resp_rdata(b_rdata),
    .busy(b_busy)
  );

  logic [W-1:0] mdl  [D];
  logic [W-1:0] mdl8 [D8];
  logic [DW-1:0]  last_rd_a;
  logic [DW8-1:0] last_rd_b;
  exp_t sb_a[$];
  exp_t sb_b[$];
  int errors = 0;
  int checks = 0;

  function automatic logic [255:0] exp_blk_a(input logic [AW-1:0] addr);
    logic [255:0] r;
    int base;
    r = '0;
    base = int'(addr) & ~(BWD - 1);
    for (int i = 0; i < BWD; i++) r[i*W +: W] = mdl[base + i];
    return r;
  endfunction

  function automatic logic [255:0] exp_blk_b(input logic [AW8-1:0] addr);
    logic [255:0] r;
    int base;
    r = '0;
    base = int'(addr) & ~(B8 - 1);
    for (int i = 0; i < B8; i++) r[i*W +: W] = mdl8[base + i];
    return r;
  endfunction

  task automatic push_exp_a(input bit wr, input bit blk,
                            input logic [AW-1:0] addr,
                            input logic [DW-1:0] wd, input int off);
    exp_t e;
    int base;
    e.rd  = !wr;
    e.lat = off + ((wr && !blk) ? LAT + 2 : LAT + BWD + 1);
    if (e.rd) begin
      e.data = exp_blk_a(addr);
      last_rd_a = e.data[DW-1:0];
    end else begin
      e.data = 256'(last_rd_a);
      if (blk) begin
        base = int'(addr) & ~(BWD - 1);
        for (int i = 0; i < BWD; i++) mdl[base + i] = wd[i*W +: W];
      end else begin
        mdl[addr] = wd[W-1:0];
      end
    end
    sb_a.push_back(e);
  endtask

  task automatic push_exp_b(input bit wr, input bit blk,
                            input logic [AW8-1:0] addr,
                            input logic [DW8-1:0] wd);
    exp_t e;
    int base;
    e.rd  = !wr;
    e.lat = (wr && !blk) ? L8 + 2 : L8 + B8 + 1;
    if (e.rd) begin
      e.data = exp_blk_b(addr);
      last_rd_b = e.data[DW8-1:0];
    end else begin
      e.data = 256'(last_rd_b);
      if (blk) begin
        base = int'(addr) & ~(B8 - 1);
        for (int i = 0; i < B8; i++) mdl8[base + i] = wd[i*W +: W];
      end else begin
        mdl8[addr] = wd[W-1:0];
      end
    end
    sb_b.push_back(e);
  endtask

  // Drive one request on the default build; returns in cycle 1 after acceptance.
  task automatic send_a(input bit wr, input bit blk,
                        input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd);
    bit acc;
    acc = 0;
    a_valid = 1; a_write = wr; a_block = blk;
    a_addr = addr; a_wdata = wd;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (a_ready) begin
        push_exp_a(wr, blk, addr, wd, 0);
        acc = 1;
      end
      @(posedge clk); #1;
    end
    a_valid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_a: request at %h not accepted", addr);
    end
  endtask

  task automatic wait_resp_a(output int cyc, output logic [DW-1:0] d,
                             output bit got);
    got = 0; d = '0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (a_resp) begin
        got = 1; d = a_rdata;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic b_op(input bit wr, input bit blk,
                      input logic [AW8-1:0] addr,
                      input logic [DW8-1:0] wd,
                      output int cyc, output logic [DW8-1:0] d,
                      output bit got);
    bit acc;
    acc = 0; got = 0; d = '0; cyc = 0;
    b_valid = 1; b_write = wr; b_block = blk;
    b_addr = addr; b_wdata = wd;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (b_ready) begin
        push_exp_b(wr, blk, addr, wd);
        acc = 1;
      end
      @(posedge clk); #1;
    end
    b_valid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL accept_b: request at %h not accepted", addr);
    end else begin
      for (cyc = 1; cyc <= 40; cyc++) begin
        if (b_resp) begin
          got = 1; d = b_rdata;
          break;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset;
    a_valid = 0; a_write = 0; a_block = 0; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_write = 0; b_block = 0; b_addr = '0; b_wdata = '0;
    for (int i = 0; i < D; i++) mdl[i] = '0;
    for (int i = 0; i < D8; i++) mdl8[i] = '0;
    last_rd_a = '0; last_rd_b = '0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", a_ready); end
    checks++;
    if (a_resp !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b want 0", a_resp); end
    checks++;
    if (a_rdata !== '0) begin errors++; $display("FAIL rst_rdata: got %h want 0", a_rdata); end
    checks++;
    if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", a_busy); end
    checks++;
    if (b_ready !== 1'b1) begin errors++; $display("FAIL rst_ready8: got %b want 1", b_ready); end
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_read_after_reset;
    int c; logic [DW-1:0] d; bit g; exp_t e;
    send_a(0, 0, 10'h010, '0);
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL rd010_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL rd010_data: got %h want %h", d, e.data[DW-1:0]); end
  endtask

  task automatic test_block_write;
    int c; logic [DW-1:0] d; bit g; exp_t e;
    send_a(1, 1, 10'h013, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL bw_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL bw_rdata_hold: got %h want %h", d, e.data[DW-1:0]); end
    send_a(0, 0, 10'h011, '0);
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL bw_rd_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL bw_rd_data: got %h want %h", d, e.data[DW-1:0]); end
  endtask

  task automatic test_single_write;
    int c; logic [DW-1:0] d; bit g; exp_t e;
    send_a(1, 0, 10'h022, {96'h0, 32'hDEADBEEF});
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL sw_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL sw_rdata_hold: got %h want %h", d, e.data[DW-1:0]); end
    send_a(0, 0, 10'h020, '0);
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL sw_rd_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL sw_rd_data: got %h want %h", d, e.data[DW-1:0]); end
  endtask

  task automatic test_back_to_back;
    int rdy_bad, nresp, w;
    bit ready8;
    exp_t e;
    rdy_bad = 0; nresp = 0; ready8 = 0;
    a_valid = 1; a_write = 0; a_block = 0; a_addr = 10'h010;
    for (w = 0; w < 20 && !a_ready; w++) begin
      @(posedge clk); #1;
    end
    push_exp_a(0, 0, 10'h010, '0, 0);
    @(posedge clk); #1;
    a_addr = 10'h020;
    for (int c = 1; c <= 22; c++) begin
      if (((c >= 1 && c <= 7) || (c >= 9 && c <= 15)) && a_ready) rdy_bad++;
      if (c == 8) begin
        ready8 = a_ready;
        push_exp_a(0, 0, 10'h020, '0, 8);
      end
      if (c == 9) a_valid = 0;
      if (a_resp) begin
        nresp++;
        if (sb_a.size() > 0) begin
          e = sb_a.pop_front();
          checks++;
          if (c !== e.lat) begin errors++; $display("FAIL b2b_lat: got cycle %0d want %0d", c, e.lat); end
          checks++;
          if (a_rdata !== e.data[DW-1:0]) begin errors++; $display("FAIL b2b_data: got %h want %h", a_rdata, e.data[DW-1:0]); end
        end
      end
      @(posedge clk); #1;
    end
    a_valid = 0;
    checks++;
    if (rdy_bad !== 0) begin errors++; $display("FAIL b2b_ready_low: got %0d ready cycles want 0", rdy_bad); end
    checks++;
    if (ready8 !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_resp: got %b want 1", ready8); end
    checks++;
    if (nresp !== 2) begin errors++; $display("FAIL b2b_resp_count: got %0d want 2", nresp); end
    sb_a.delete();
  endtask

  task automatic test_mid_reset;
    int c, nspur; logic [DW-1:0] d; bit g; exp_t e;
    send_a(1, 1, 10'h010, {32'h14, 32'h13, 32'h12, 32'h11});
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 0;
    #1;
    checks++;
    if (a_ready !== 1'b1) begin errors++; $display("FAIL mrst_ready: got %b want 1", a_ready); end
    checks++;
    if (a_resp !== 1'b0) begin errors++; $display("FAIL mrst_resp: got %b want 0", a_resp); end
    sb_a.delete();
    for (int i = 0; i < D; i++) mdl[i] = '0;
    for (int i = 0; i < D8; i++) mdl8[i] = '0;
    last_rd_a = '0; last_rd_b = '0;
    a_valid = 1; a_write = 0; a_block = 0; a_addr = 10'h010;
    @(negedge clk) rst_n = 1;
    push_exp_a(0, 0, 10'h010, '0, 0);
    @(posedge clk); #1;
    a_valid = 0;
    checks++;
    if (a_busy !== 1'b1) begin errors++; $display("FAIL mrst_accept: busy got %b want 1", a_busy); end
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL mrst_rd_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL mrst_rd_data: got %h want %h", d, e.data[DW-1:0]); end
    send_a(0, 0, 10'h020, '0);
    wait_resp_a(c, d, g);
    e = sb_a.pop_front();
    checks++;
    if (d !== e.data[DW-1:0]) begin errors++; $display("FAIL mrst_rd020_data: got %h want %h", d, e.data[DW-1:0]); end
    nspur = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (a_resp) nspur++;
    end
    checks++;
    if (nspur !== 0) begin errors++; $display("FAIL mrst_spurious_resp: got %0d want 0", nspur); end
  endtask

  task automatic test_lat0_bw8;
    int c; logic [DW8-1:0] d, wd; bit g; exp_t e;
    b_op(0, 0, 6'h00, '0, c, d, g);
    e = sb_b.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL l0_rd_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW8-1:0]) begin errors++; $display("FAIL l0_rd_data: got %h want %h", d, e.data[DW8-1:0]); end
    for (int i = 0; i < B8; i++) wd[i*W +: W] = 32'hB0 + i;
    b_op(1, 1, 6'h3F, wd, c, d, g);
    e = sb_b.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL l0_bw_lat: got %0d want %0d", c, e.lat); end
    b_op(0, 0, 6'h3F, '0, c, d, g);
    e = sb_b.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL l0_top_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW8-1:0]) begin errors++; $display("FAIL l0_top_data: got %h want %h", d, e.data[DW8-1:0]); end
    b_op(1, 0, 6'h3D, {224'h0, 32'h5555AAAA}, c, d, g);
    e = sb_b.pop_front();
    checks++;
    if (!g || c !== e.lat) begin errors++; $display("FAIL l0_sw_lat: got %0d want %0d", c, e.lat); end
    checks++;
    if (d !== e.data[DW8-1:0]) begin errors++; $display("FAIL l0_sw_hold: got %h want %h", d, e.data[DW8-1:0]); end
    b_op(0, 0, 6'h38, '0, c, d, g);
    e = sb_b.pop_front();
    checks++;
    if (d !== e.data[DW8-1:0]) begin errors++; $display("FAIL l0_sw_rd_data: got %h want %h", d, e.data[DW8-1:0]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_read_after_reset();
    test_block_write();
    test_single_write();
    test_back_to_back();
    test_mid_reset();
    test_lat0_bw8();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
